// File: rtl/median_pkg.sv
// Shared types and constants for the median-filter scheduler.
package median_pkg;

    // Scheduler states, one per phase of a pixel's processing.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COPY_RD,
        ST_COPY_WR,
        ST_WIN_RD,
        ST_WIN_DRAIN,
        ST_WAIT_MED,
        ST_MED_WR,
        ST_FIN
    } state_t;

    typedef logic [7:0] pixel_t;

    // Number of samples in a 3x3 neighbourhood and the width of its index.
    localparam int WIN_SIZE = 9;
    localparam int KW       = 4;

    // Row offset (0..2) of neighbourhood sample k, i.e. k / 3.
    function automatic logic [1:0] win_row(input logic [KW-1:0] k);
        logic [1:0] r;
        case (k)
            4'd0, 4'd1, 4'd2: r = 2'd0;
            4'd3, 4'd4, 4'd5: r = 2'd1;
            default:          r = 2'd2;
        endcase
        return r;
    endfunction

    // Column offset (0..2) of neighbourhood sample k, i.e. k % 3.
    function automatic logic [1:0] win_col(input logic [KW-1:0] k);
        logic [1:0] c;
        case (k)
            4'd0, 4'd3, 4'd6: c = 2'd0;
            4'd1, 4'd4, 4'd7: c = 2'd1;
            default:          c = 2'd2;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/median_win_addr.sv
// Combinational address of neighbourhood sample k around pixel (x,y).
// Only ever used for interior pixels, so the -1 offsets cannot underflow.
module median_win_addr
    import median_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int AW    = 6,
    parameter int XW    = 3,
    parameter int YW    = 3
) (
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    input  logic [KW-1:0] i_k,
    output logic [AW-1:0] o_addr
);

    logic [AW-1:0] w_row;
    logic [AW-1:0] w_col;

    assign w_row  = AW'(i_y) + AW'(win_row(i_k)) - AW'(1);
    assign w_col  = AW'(i_x) + AW'(win_col(i_k)) - AW'(1);
    assign o_addr = w_row * AW'(IMG_W) + w_col;

endmodule

// File: rtl/median_sched.sv
// Frame scheduler for a 3x3 median filter: copies border pixels, streams the
// 3x3 window of each interior pixel into an external median unit and writes
// its result back to the destination RAM.
module median_sched
    import median_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = $clog2(IMG_W*IMG_H)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_raddr,
    input  logic [7:0]    i_rdata,
    output logic [AW-1:0] o_waddr,
    output logic [7:0]    o_wdata,
    output logic          o_we,
    output logic [7:0]    o_mdi,
    output logic          o_mdsi,
    input  logic [7:0]    i_mdo,
    input  logic          i_mdso
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
    localparam logic [AW-1:0] PIX_LAST = AW'(IMG_W*IMG_H - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(WIN_SIZE - 1);

    state_t        r_state, w_state_next;
    logic [XW-1:0] r_x, w_x_next;
    logic [YW-1:0] r_y, w_y_next;
    logic [AW-1:0] r_pix, w_pix_next;
    logic [KW-1:0] r_k, w_k_next;
    pixel_t        r_med, w_med_next;

    logic [AW-1:0] w_win_addr;
    logic [XW-1:0] w_x_adv;
    logic [YW-1:0] w_y_adv;
    logic          w_adv_border;
    logic          w_adv;

    median_win_addr #(
        .IMG_W (IMG_W),
        .AW    (AW),
        .XW    (XW),
        .YW    (YW)
    ) u_win_addr (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_k    (r_k),
        .o_addr (w_win_addr)
    );

    // Raster position of the following pixel; x wraps into the next row.
    assign w_x_adv      = (r_x == X_LAST) ? '0 : r_x + XW'(1);
    assign w_y_adv      = (r_x == X_LAST) ? r_y + YW'(1) : r_y;
    assign w_adv_border = (w_x_adv == '0) || (w_x_adv == X_LAST) ||
                          (w_y_adv == '0) || (w_y_adv == Y_LAST);

    // State and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_pix   <= '0;
            r_k     <= '0;
            r_med   <= '0;
        end else begin
            r_state <= w_state_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_pix   <= w_pix_next;
            r_k     <= w_k_next;
            r_med   <= w_med_next;
        end
    end

    // Next-state logic and outputs decoded from the current state.
    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_pix_next   = r_pix;
        w_k_next     = r_k;
        w_med_next   = r_med;
        w_adv        = 1'b0;
        o_busy       = (r_state != ST_IDLE) && (r_state != ST_FIN);
        o_done       = 1'b0;
        o_raddr      = '0;
        o_waddr      = '0;
        o_wdata      = '0;
        o_we         = 1'b0;
        o_mdi        = '0;
        o_mdsi       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Pixel (0,0) is always a border pixel.
                if (i_start) begin
                    w_state_next = ST_COPY_RD;
                    w_x_next     = '0;
                    w_y_next     = '0;
                    w_pix_next   = '0;
                    w_k_next     = '0;
                end
            end
            ST_COPY_RD: begin
                o_raddr      = r_pix;
                w_state_next = ST_COPY_WR;
            end
            ST_COPY_WR: begin
                o_we    = 1'b1;
                o_waddr = r_pix;
                o_wdata = i_rdata;
                w_adv   = 1'b1;
            end
            ST_WIN_RD: begin
                // Read data lags the address by one cycle, so the median
                // strobe starts on the second read and ends in the drain.
                o_raddr = w_win_addr;
                if (r_k != '0) begin
                    o_mdsi = 1'b1;
                    o_mdi  = i_rdata;
                end
                if (r_k == K_LAST) begin
                    w_k_next     = '0;
                    w_state_next = ST_WIN_DRAIN;
                end else begin
                    w_k_next = r_k + KW'(1);
                end
            end
            ST_WIN_DRAIN: begin
                o_mdsi       = 1'b1;
                o_mdi        = i_rdata;
                w_state_next = ST_WAIT_MED;
            end
            ST_WAIT_MED: begin
                // Only results arriving here are accepted.
                if (i_mdso) begin
                    w_med_next   = i_mdo;
                    w_state_next = ST_MED_WR;
                end
            end
            ST_MED_WR: begin
                o_we    = 1'b1;
                o_waddr = r_pix;
                o_wdata = r_med;
                w_adv   = 1'b1;
            end
            ST_FIN: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // After each write move to the next pixel, or finish the frame.
        if (w_adv) begin
            if (r_pix == PIX_LAST) begin
                w_state_next = ST_FIN;
            end else begin
                w_pix_next   = r_pix + AW'(1);
                w_x_next     = w_x_adv;
                w_y_next     = w_y_adv;
                w_state_next = w_adv_border ? ST_COPY_RD : ST_WIN_RD;
            end
        end
    end

endmodule

// File: doc/median_sched.md
MEDIAN_SCHED -- requirements
Module: median_sched

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 8, meaning image height in pixels (>=3).
REQ-003 SHALL have parameter AW, default $clog2(IMG_W*IMG_H), meaning pixel address width.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 nRST  input  1  reset, asynchronous, active-low.
REQ-006 START  input  1  one-cycle request to filter the whole image.
REQ-007 BUSY  output  1  high from the cycle after START is accepted until DONE.
REQ-008 DONE  output  1  one-cycle pulse after the last result write.
REQ-009 RADDR  output  AW  source RAM read address; synchronous read, data valid on RDATA the next cycle.
REQ-010 RDATA  input  8  source RAM read data.
REQ-011 WADDR  output  AW  destination RAM write address.
REQ-012 WDATA  output  8  destination RAM write data.
REQ-013 WE  output  1  destination write strobe, one cycle per pixel.
REQ-014 MDI  output  8  pixel stream to median filter (DI).
REQ-015 MDSI  output  1  median input strobe (DSI).
REQ-016 MDO  input  8  median result (DO).
REQ-017 MDSO  input  1  median result valid, one-cycle pulse (DSO).

Function
REQ-018 SHALL scan pixels in raster order, address = y*IMG_W + x, x fastest.
REQ-019 Border pixel (x=0, x=IMG_W-1, y=0, y=IMG_H-1): SHALL read it and write RDATA unchanged to the same address, with WE one cycle after the read.
REQ-020 Interior pixel: SHALL issue 9 reads in neighbourhood order (y-1,x-1),(y-1,x),(y-1,x+1),(y,x-1)..(y+1,x+1), on consecutive cycles.
REQ-021 MDSI SHALL be high for exactly 9 consecutive cycles, aligned with the 9 RDATA values, with MDI = RDATA combinationally or registered such that MDI/MDSI align; MDSI low otherwise.
REQ-022 After MDSI falls, SHALL wait for MDSO; on MDSO SHALL capture MDO and assert WE the next cycle with WADDR = current pixel, WDATA = captured MDO.
REQ-023 MDSO received outside WAIT state SHALL be ignored.
REQ-024 FSM states: IDLE, COPY_RD, COPY_WR, WIN_RD, WIN_DRAIN, WAIT_MED, MED_WR, FIN; FIN asserts DONE one cycle, returns to IDLE.
REQ-025 Transitions: IDLE->(START) first pixel state; after each write -> next pixel's read state, or FIN after pixel IMG_W*IMG_H-1.
REQ-026 START while BUSY SHALL be ignored; START in the FIN cycle SHALL be ignored.
REQ-027 x and y counters SHALL wrap x at IMG_W-1 to 0 with y+1; no address beyond IMG_W*IMG_H-1 SHALL ever be driven.
REQ-028 At most one MDSI burst SHALL be outstanding; no new burst before the previous MDSO.
REQ-029 Latency: border pixel 2 cycles; interior pixel 9 read + 1 drain + median latency + 1 write cycles.
REQ-030 WE, DONE, MDSI SHALL never be high simultaneously with each other in a cycle except as implied by pipelining (WE and MDSI never together).

Reset
REQ-031 On nRST low, asynchronously: state IDLE, BUSY=0, DONE=0, WE=0, MDSI=0, RADDR=0, WADDR=0, WDATA=0, MDI=0, counters 0.
REQ-032 Reset mid-frame SHALL abort; no write SHALL occur after release until a new START.

Structure
REQ-033 Shared package median_pkg SHALL hold the FSM state enum typedef, pixel_t (8-bit) and WIN_SIZE=9.
REQ-034 Sub-module median_win_addr SHALL compute neighbourhood address from (x,y,k), k=0..8, combinationally.

Verification
REQ-035 IMG_W=IMG_H=4, all pixels 50, START -> 16 writes all 50, DONE one cycle after last WE.
REQ-036 4x4 field of 10 with pixel (1,1)=255 -> destination (1,1)=10, border pixels copied unchanged.
REQ-037 Interior neighbourhood values 1..9 in scan order -> written median 5; MDSI exactly 9 cycles per burst.
REQ-038 START pulsed while BUSY -> ignored, exactly 16 writes, single DONE.
REQ-039 nRST low during WAIT_MED -> all outputs 0 immediately, no WE after release until new START; new START completes full frame.
REQ-040 Spurious MDSO while in WIN_RD -> no WE, result taken only from MDSO in WAIT_MED.
